// File: rtl/encode_eight_to_three.sv
// Priority encoder with a pending-event register: 8 request lines in, one 3-bit code out per accept.
// Latency: an event seen at rising edge N is presented after edge N (single register stage).
// Backpressure: valid/ready; the presented code holds while iReady is low, and new events collect in oPending.
module encode_eight_to_three #(
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEnable,
  input  logic [7:0] iReq,
  input  logic       iReady,
  output logic       oValid,
  output logic [2:0] oCode,
  output logic [7:0] oPending,
  output logic       oDrop,
  output logic       oBusy
);

  logic [7:0] cand;
  logic       load;
  logic       drop_nxt;
  logic [2:0] sel;
  logic [7:0] sel_mask;

  // Merge new requests into the pending set and decide whether the output stage can take a new code
  always_comb begin
    cand     = oPending | (iEnable ? iReq : 8'h00);
    load     = !oValid || iReady;
    // A request landing on a bit that is already pending is merged, so it is reported as a drop.
    // A request matching the code currently presented is not pending, so it is a fresh event.
    drop_nxt = iEnable && (|(iReq & oPending));
  end

  // Pick the index to serve next; the later assignment in each loop wins, giving the chosen end priority
  always_comb begin
    sel = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (cand[i]) sel = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (cand[i]) sel = 3'(i);
      end
    end
    sel_mask = 8'h01 << sel;
  end

  // Output stage and pending register; oCode is frozen whenever a presented code is not accepted
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid   <= 1'b0;
      oCode    <= 3'b000;
      oPending <= 8'h00;
      oDrop    <= 1'b0;
    end else begin
      oDrop <= drop_nxt;
      if (load) begin
        if (|cand) begin
          oValid   <= 1'b1;
          oCode    <= sel;
          oPending <= cand & ~sel_mask;
        end else begin
          // oCode deliberately keeps its last value when the stage empties
          oValid   <= 1'b0;
          oPending <= 8'h00;
        end
      end else begin
        oPending <= cand;
      end
    end
  end

  assign oBusy = oValid | (|oPending);

endmodule

// File: tb/tb_encode_eight_to_three.sv
// Bench for encode_eight_to_three: both priority orders driven by the same stimulus.
// Directed scenarios with literal expectations, then randomized traffic against a behavioural model.
// Outputs are sampled on the falling edge and #1 after the rising edge.
module tb_encode_eight_to_three;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iEnable = 1'b0;
  logic [7:0] iReq = 8'h00;
  logic       iReady = 1'b0;

  logic       v0, v1, d0, d1, b0, b1;
  logic [2:0] c0, c1;
  logic [7:0] p0, p1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 iClk = ~iClk;

  encode_eight_to_three #(.HIGH_FIRST(1'b0)) dut_lo (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iReq(iReq), .iReady(iReady),
    .oValid(v0), .oCode(c0), .oPending(p0), .oDrop(d0), .oBusy(b0)
  );

  encode_eight_to_three #(.HIGH_FIRST(1'b1)) dut_hi (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iReq(iReq), .iReady(iReady),
    .oValid(v1), .oCode(c1), .oPending(p1), .oDrop(d1), .oBusy(b1)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       v;
    logic [2:0] code;
    logic [7:0] pend;
    logic       drop;
  } mstate_t;

  mstate_t m0 = '0;
  mstate_t m1 = '0;

  // Index of the lowest or highest set bit, via arithmetic on the integer value
  function automatic int pick(input int x, input bit high_first);
    int lo;
    if (high_first) return $clog2(x + 1) - 1;
    lo = x & (-x);
    return $clog2(lo);
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input bit hf, input logic rst,
                                         input logic en, input logic [7:0] req, input logic rdy);
    mstate_t n;
    int cand;
    int k;
    n = s;
    if (rst) begin
      n = '0;
      return n;
    end
    cand   = int'(s.pend) | (en ? int'(req) : 0);
    n.drop = en && ((int'(req) & int'(s.pend)) != 0);
    if (!s.v || rdy) begin
      if (cand != 0) begin
        k      = pick(cand, hf);
        n.v    = 1'b1;
        n.code = 3'(k);
        n.pend = 8'(cand - (1 << k));
      end else begin
        n.v    = 1'b0;
        n.pend = 8'h00;
      end
    end else begin
      n.pend = 8'(cand);
    end
    return n;
  endfunction

  always @(posedge iClk) begin
    m0 <= model_next(m0, 1'b0, iRst, iEnable, iReq, iReady);
    m1 <= model_next(m1, 1'b1, iRst, iEnable, iReq, iReady);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model
  always @(negedge iClk) begin
    if (chk_en) begin
      chk("lo.valid",   32'(v0), 32'(m0.v));
      chk("lo.pending", 32'(p0), 32'(m0.pend));
      chk("lo.drop",    32'(d0), 32'(m0.drop));
      chk("lo.busy",    32'(b0), 32'(m0.v | (|m0.pend)));
      chk("hi.valid",   32'(v1), 32'(m1.v));
      chk("hi.pending", 32'(p1), 32'(m1.pend));
      chk("hi.drop",    32'(d1), 32'(m1.drop));
      chk("hi.busy",    32'(b1), 32'(m1.v | (|m1.pend)));
      // oCode is only meaningful while valid, and right after reset it is pinned to zero
      if (m0.v || m0.code == 3'd0) chk("lo.code", 32'(c0), 32'(m0.code));
      if (m1.v || m1.code == 3'd0) chk("hi.code", 32'(c1), 32'(m1.code));
    end
  end

  // Drive one cycle of inputs, then land #1 after the rising edge that consumed them
  task automatic cyc(input logic en, input logic [7:0] req, input logic rdy);
    iEnable = en;
    iReq    = req;
    iReady  = rdy;
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    cyc(1'b1, 8'hFF, 1'b1);
    iRst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_en = 1'b1;
    chk("rst.valid", 32'(v0), 0);
    chk("rst.code",  32'(c0), 0);
    chk("rst.pend",  32'(p0), 0);
    chk("rst.drop",  32'(d0), 0);
    chk("rst.busy",  32'(b1), 0);

    // Single event, visible one edge later, then idle
    cyc(1'b1, 8'h20, 1'b1);
    chk("single.valid", 32'(v0), 1);
    chk("single.code",  32'(c0), 5);
    chk("single.model", 32'(m0.code), 5);
    cyc(1'b0, 8'h00, 1'b1);
    chk("single.idle", 32'(v0), 0);
    chk("single.busy", 32'(b0), 0);

    // Burst priority order in both directions
    cyc(1'b1, 8'h91, 1'b1);
    chk("burst.lo0", 32'(c0), 0);
    chk("burst.hi0", 32'(c1), 7);
    chk("burst.pend_lo", 32'(p0), 32'h90);
    chk("burst.pend_model_hi", 32'(m1.pend), 32'h11);
    cyc(1'b0, 8'h00, 1'b1);
    chk("burst.lo1", 32'(c0), 4);
    chk("burst.hi1", 32'(c1), 4);
    cyc(1'b0, 8'h00, 1'b1);
    chk("burst.lo2", 32'(c0), 7);
    chk("burst.hi2", 32'(c1), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("burst.end_lo", 32'(v0), 0);
    chk("burst.end_hi", 32'(v1), 0);

    // Stall stability: higher-priority arrival must not displace the presented code
    cyc(1'b1, 8'h08, 1'b0);
    chk("stall.code0", 32'(c0), 3);
    cyc(1'b1, 8'h01, 1'b0);
    chk("stall.hold_lo", 32'(c0), 3);
    chk("stall.hold_hi", 32'(c1), 3);
    chk("stall.pend",    32'(p0), 32'h01);
    cyc(1'b0, 8'h00, 1'b1);
    chk("stall.next", 32'(c0), 0);
    cyc(1'b0, 8'h00, 1'b1);

    // Drop: second request lands on a still-pending bit (low-first case)
    cyc(1'b1, 8'h06, 1'b0);
    chk("drop.code1", 32'(c0), 1);
    chk("drop.none",  32'(d0), 0);
    cyc(1'b1, 8'h04, 1'b0);
    chk("drop.pulse_lo", 32'(d0), 1);
    chk("drop.none_hi",  32'(d1), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drop.code2", 32'(c0), 2);
    chk("drop.clear", 32'(d0), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drop.done", 32'(v0), 0);

    // Re-request of the presented code is a new event, not a drop
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h10, 1'b0);
    chk("same.nodrop", 32'(d0), 0);
    chk("same.pend",   32'(p0), 32'h10);
    cyc(1'b0, 8'h00, 1'b1);
    chk("same.again", 32'(c0), 4);
    cyc(1'b0, 8'h00, 1'b1);

    // Enable gating, and draining with enable low
    cyc(1'b0, 8'hFF, 1'b1);
    chk("gate.valid", 32'(v0), 0);
    chk("gate.drop",  32'(d0), 0);
    cyc(1'b1, 8'h0C, 1'b0);
    chk("gate.code", 32'(c0), 2);
    cyc(1'b0, 8'hFF, 1'b1);
    chk("gate.drain", 32'(c0), 3);
    cyc(1'b0, 8'h00, 1'b1);
    chk("gate.empty", 32'(v0), 0);

    // Reset mid-burst discards everything
    cyc(1'b1, 8'hFF, 1'b1);
    chk("mid.c0", 32'(c0), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid.c1", 32'(c0), 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid.c2", 32'(c0), 2);
    do_reset();
    chk("mid.valid", 32'(v0), 0);
    chk("mid.pend",  32'(p0), 0);
    chk("mid.busy",  32'(b0), 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("mid.nomore", 32'(v0), 0);
    cyc(1'b1, 8'h40, 1'b1);
    chk("post.valid", 32'(v0), 1);
    chk("post.code",  32'(c0), 6);

    // Randomized traffic, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      logic       en, rdy;
      logic [7:0] req;
      en   = ($urandom_range(0, 7) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      req  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      iRst = ($urandom_range(0, 199) == 0);
      cyc(en, req, rdy);
    end
    iRst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/encode_eight_to_three.md
ENCODE_EIGHT_TO_THREE -- requirements
Module: encode_eight_to_three

Interface
REQ-001 Parameter: HIGH_FIRST, default 0, priority select (0 = lowest set index served first, 1 = highest set index served first).
REQ-002 iClk  input  1  single clock; all state updates on rising edge.
REQ-003 iRst  input  1  reset, synchronous, active-high.
REQ-004 iEnable  input  1  request capture enable; when low, iReq is ignored.
REQ-005 iReq  input  8  request lines; each set bit is one event for that index, sampled every edge.
REQ-006 iReady  input  1  consumer accepts oCode this cycle.
REQ-007 oValid  output  1  oCode holds a valid encoded event.
REQ-008 oCode  output  3  encoded index of the presented event.
REQ-009 oPending  output  8  pending-event register, not yet presented.
REQ-010 oDrop  output  1  one-cycle pulse: an incoming event merged into an already pending bit.
REQ-011 oBusy  output  1  oValid OR any oPending bit set.

Function
REQ-012 All outputs SHALL be registered or decoded only from registers; no combinational path from any input to any output.
REQ-013 Candidate set SHALL be cand = oPending OR (iEnable ? iReq : 8'h00).
REQ-014 Load condition SHALL be load = !oValid OR iReady (output stage empty, or being accepted this edge).
REQ-015 On an edge with load and cand != 0: oValid <= 1, oCode <= priority index of cand per HIGH_FIRST, oPending <= cand with that bit cleared.
REQ-016 On an edge with load and cand == 0: oValid <= 0, oCode holds its previous value, oPending <= 8'h00.
REQ-017 On an edge without load (oValid=1, iReady=0): oValid and oCode SHALL hold unchanged; oPending <= cand.
REQ-018 oCode SHALL never change while oValid=1 and iReady=0, even if a higher-priority event arrives.
REQ-019 Latency: event on idle block at edge N SHALL give oValid=1 with its code after edge N (visible in cycle N+1).
REQ-020 Throughput: with iReady held high, one event per cycle SHALL be presented; back-to-back accepts need no bubble.
REQ-021 oDrop SHALL be 1 after an edge where iEnable=1 and any iReq[k]=1 with oPending[k]=1 before that edge; else 0; merged events count once.
REQ-022 An incoming iReq[k] equal to the currently presented oCode SHALL be a new event, entered into oPending (not a drop).
REQ-023 iEnable=0 SHALL NOT stop draining: pending events continue to be presented and accepted.
REQ-024 iReady while oValid=0 SHALL have no effect beyond enabling load.
REQ-025 oBusy SHALL equal oValid OR (|oPending) from the current register values.

Reset
REQ-026 On edge with iRst=1: oValid=0, oCode=3'b000, oPending=8'h00, oDrop=0; iReq, iEnable, iReady ignored that edge.
REQ-027 Reset mid-operation SHALL discard all pending and presented events; no event survives reset.
REQ-028 First edge after iRst falls SHALL behave as idle (REQ-019 latency applies).

Verification
REQ-029 Single event: reset, iEnable=1, iReq=8'h20 one cycle, iReady=1 -> next cycle oValid=1, oCode=5; following cycle oValid=0, oBusy=0.
REQ-030 Burst priority, HIGH_FIRST=0: iReq=8'h91 one cycle, iReady=1 -> oCode 0,4,7 on three consecutive cycles, then oValid=0; HIGH_FIRST=1 -> 7,4,0.
REQ-031 Stall stability: present oCode=3 with iReady=0, then iReq=8'h01 -> oCode stays 3, oPending=8'h01; iReady=1 -> next oCode=0.
REQ-032 Drop: iReady=0, iReq=8'h06 then iReq=8'h04 -> oDrop=1 one cycle after second edge; total codes delivered = 2 (1 then 2).
REQ-033 Enable gating: iEnable=0, iReq=8'hFF -> oValid stays 0, oDrop=0; with pending events, iEnable=0 still drains them.
REQ-034 Reset mid-burst: iReq=8'hFF, after 2 accepts assert iRst one cycle -> oValid=0, oPending=8'h00, oBusy=0, no further codes.
